// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: shares the single frame-buffer write port among three
// drawing engines. Whole bursts are granted (round-robin or fixed priority),
// the granted engine's pixels are registered and clipped to the screen, and a
// watchdog reclaims the port from an engine that never signals done.
module draw_port_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_BURST      = 19201,
  parameter int SCREEN_W       = 160,
  parameter int SCREEN_H       = 120
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [NUM_REQ-1:0]     plot_en,
  input  logic [8*NUM_REQ-1:0]   x_in,
  input  logic [7*NUM_REQ-1:0]   y_in,
  input  logic [3*NUM_REQ-1:0]   color_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             X,
  output logic [6:0]             Y,
  output logic [2:0]             color_out,
  output logic                   draw_enable,
  output logic                   busy,
  output logic                   timeout_flag
);

  localparam int WD_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            tflag_q, tflag_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [2:0]      col_q, col_d;
  logic            de_q, de_d;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [7:0]      x_sel;
  logic [6:0]      y_sel;
  logic [2:0]      c_sel;
  logic            pe_sel, done_sel, wd_expire, in_bounds;

  // Requester index visited k steps after the round-robin pointer, wrapping 2 -> 0.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= NUM_REQ) t = t - NUM_REQ;
    return 2'(t);
  endfunction

  // Pick the next winner; descending scan so the highest-priority candidate is written last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (FIXED_PRIORITY != 0) begin
        if (req[k]) begin
          win_found = 1'b1;
          win_idx   = 2'(k);
        end
      end else begin
        if (req[rr_idx(ptr_q, k)]) begin
          win_found = 1'b1;
          win_idx   = rr_idx(ptr_q, k);
        end
      end
    end
  end

  // Route the granted requester's pixel lane and evaluate clipping / watchdog expiry.
  always_comb begin
    x_sel     = x_in[8*gidx_q +: 8];
    y_sel     = y_in[7*gidx_q +: 7];
    c_sel     = color_in[3*gidx_q +: 3];
    pe_sel    = plot_en[gidx_q];
    done_sel  = done[gidx_q];
    wd_expire = (wdog_q == WD_W'(MAX_BURST - 1));
    in_bounds = (int'(x_sel) < SCREEN_W) && (int'(y_sel) < SCREEN_H);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a burst ends only on done from the owner or watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (win_found) state_d = S_GRANT;
      S_GRANT:   state_d = S_BURST;
      S_BURST:   if (done_sel || wd_expire) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Next values for grant owner, pointer, watchdog, sticky flag and the pixel registers.
  always_comb begin
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    tflag_d = tflag_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    de_d    = 1'b0;
    case (state_q)
      S_IDLE:    if (win_found) gidx_d = win_idx;
      S_GRANT:   wdog_d = '0;
      S_BURST: begin
        wdog_d = wdog_q + 1'b1;
        x_d    = x_sel;
        y_d    = y_sel;
        col_d  = c_sel;
        de_d   = pe_sel && in_bounds;
        // A done arriving on the expiry cycle wins: it is a normal completion.
        if (!done_sel && wd_expire) tflag_d = 1'b1;
      end
      S_RELEASE: ptr_d = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
      default:   ;
    endcase
  end

  // Control and pixel registers; reset also clears the pixel outputs so nothing is written after it.
  always_ff @(posedge clock) begin
    if (reset) begin
      gidx_q  <= 2'd0;
      ptr_q   <= 2'd0;
      wdog_q  <= '0;
      tflag_q <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= 3'd0;
      de_q    <= 1'b0;
    end else begin
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      tflag_q <= tflag_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      de_q    <= de_d;
    end
  end

  // Outputs: grant is one-hot while the port is owned (grant and burst states).
  always_comb begin
    grant        = '0;
    if (state_q == S_GRANT || state_q == S_BURST) grant = NUM_REQ'(1) << gidx_q;
    busy         = (state_q != S_IDLE);
    X            = x_q;
    Y            = y_q;
    color_out    = col_q;
    draw_enable  = de_q;
    timeout_flag = tflag_q;
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Directed bench for draw_port_arbiter: three instances (round-robin,
// fixed priority, short watchdog) share one stimulus bus.
module tb_draw_port_arbiter;

  logic        clock, reset;
  logic [2:0]  req, done, plot_en;
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  color_in;

  logic [2:0] g0, gf, gw;
  logic [7:0] x0, xf, xw;
  logic [6:0] y0, yf, yw;
  logic [2:0] c0, cf, cw;
  logic       de0, def, dew, b0, bf, bw, t0, tf, tw;

  int checks   = 0;
  int failures = 0;

  draw_port_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done), .plot_en(plot_en),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(g0), .X(x0), .Y(y0),
    .color_out(c0), .draw_enable(de0), .busy(b0), .timeout_flag(t0));

  draw_port_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clock(clock), .reset(reset), .req(req), .done(done), .plot_en(plot_en),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(gf), .X(xf), .Y(yf),
    .color_out(cf), .draw_enable(def), .busy(bf), .timeout_flag(tf));

  draw_port_arbiter #(.FIXED_PRIORITY(0), .MAX_BURST(8)) dut_wd (
    .clock(clock), .reset(reset), .req(req), .done(done), .plot_en(plot_en),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .grant(gw), .X(xw), .Y(yw),
    .color_out(cw), .draw_enable(dew), .busy(bw), .timeout_flag(tw));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_pix();
    plot_en  = 3'b000;
    done     = 3'b000;
    x_in     = '0;
    y_in     = '0;
    color_in = '0;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    plot_en[i]         = 1'b1;
    x_in[8*i +: 8]     = 8'(x);
    y_in[7*i +: 7]     = 7'(y);
    color_in[3*i +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    clear_pix();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 3'b000;
    clear_pix();
    step();
    step();
    checks++; if (g0 !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", g0); end
    checks++; if (x0 !== 8'd0 || y0 !== 7'd0 || c0 !== 3'd0) begin failures++; $display("FAIL reset_xyc got=%0d,%0d,%0d exp=0,0,0", x0, y0, c0); end
    checks++; if (de0 !== 1'b0 || b0 !== 1'b0 || t0 !== 1'b0) begin failures++; $display("FAIL reset_flags got de=%b busy=%b to=%b exp=0", de0, b0, t0); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int de_cnt;
    de_cnt = 0;
    do_reset();
    req = 3'b001;
    step();
    checks++; if (g0 !== 3'b001 || b0 !== 1'b1) begin failures++; $display("FAIL single_grant got=%b busy=%b exp=001 busy=1", g0, b0); end
    req = 3'b000;
    step();
    checks++; if (g0 !== 3'b001 || de0 !== 1'b0) begin failures++; $display("FAIL single_burst0 got g=%b de=%b exp g=001 de=0", g0, de0); end
    for (int k = 0; k < 4; k++) begin
      clear_pix();
      set_pix(0, 10 + k, 20, k + 1);
      set_pix(1, 99, 99, 6);
      if (k == 3) done = 3'b001;
      step();
      if (de0 === 1'b1) de_cnt++;
      checks++; if (de0 !== 1'b1 || x0 !== 8'(10 + k) || y0 !== 7'd20 || c0 !== 3'(k + 1)) begin
        failures++; $display("FAIL single_pix%0d got de=%b x=%0d y=%0d c=%0d exp de=1 x=%0d y=20 c=%0d", k, de0, x0, y0, c0, 10 + k, k + 1);
      end
      checks++; if (g0 !== ((k == 3) ? 3'b000 : 3'b001)) begin failures++; $display("FAIL single_hold%0d got=%b", k, g0); end
    end
    clear_pix();
    step();
    checks++; if (de0 !== 1'b0 || b0 !== 1'b0 || g0 !== 3'b000) begin failures++; $display("FAIL single_idle got de=%b busy=%b g=%b exp 0,0,000", de0, b0, g0); end
    checks++; if (de_cnt != 4) begin failures++; $display("FAIL single_de_count got=%0d exp=4", de_cnt); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    int g;
    do_reset();
    req = 3'b111;
    step();
    for (int b = 0; b < 4; b++) begin
      g   = b % 3;
      exp = 3'b001 << g;
      checks++; if (g0 !== exp) begin failures++; $display("FAIL rr_order%0d got=%b exp=%b", b, g0, exp); end
      step();
      clear_pix();
      for (int i = 0; i < 3; i++) set_pix(i, 16 * i, i + 1, i + 1);
      done = 3'b111 & ~exp;
      step();
      checks++; if (de0 !== 1'b1 || x0 !== 8'(16 * g) || y0 !== 7'(g + 1) || g0 !== exp) begin
        failures++; $display("FAIL rr_pix_a%0d got de=%b x=%0d y=%0d g=%b exp x=%0d y=%0d", b, de0, x0, y0, g0, 16 * g, g + 1);
      end
      clear_pix();
      for (int i = 0; i < 3; i++) set_pix(i, 16 * i + 1, i + 1, i + 1);
      done = exp;
      step();
      checks++; if (x0 !== 8'(16 * g + 1) || c0 !== 3'(g + 1) || g0 !== 3'b000) begin
        failures++; $display("FAIL rr_pix_b%0d got x=%0d c=%0d g=%b exp x=%0d c=%0d g=000", b, x0, c0, g0, 16 * g + 1, g + 1);
      end
      clear_pix();
      step();
      step();
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req = 3'b110;
    step();
    checks++; if (gf !== 3'b010) begin failures++; $display("FAIL fp_first got=%b exp=010", gf); end
    req = 3'b100;
    step();
    req = 3'b101;
    clear_pix();
    set_pix(1, 70, 30, 3);
    set_pix(0, 5, 5, 1);
    step();
    checks++; if (gf !== 3'b010 || xf !== 8'd70) begin failures++; $display("FAIL fp_no_preempt got g=%b x=%0d exp g=010 x=70", gf, xf); end
    clear_pix();
    set_pix(1, 71, 30, 3);
    done = 3'b010;
    step();
    checks++; if (gf !== 3'b000 || xf !== 8'd71) begin failures++; $display("FAIL fp_release got g=%b x=%0d exp g=000 x=71", gf, xf); end
    clear_pix();
    step();
    step();
    checks++; if (gf !== 3'b001) begin failures++; $display("FAIL fp_next got=%b exp=001", gf); end
  endtask

  task automatic test_clipping();
    do_reset();
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    clear_pix(); set_pix(0, 159, 119, 7);
    step();
    checks++; if (de0 !== 1'b1 || x0 !== 8'd159 || y0 !== 7'd119 || c0 !== 3'd7) begin failures++; $display("FAIL clip_edge got de=%b x=%0d y=%0d c=%0d exp 1,159,119,7", de0, x0, y0, c0); end
    clear_pix(); set_pix(0, 160, 5, 2);
    step();
    checks++; if (de0 !== 1'b0 || x0 !== 8'd160 || y0 !== 7'd5 || c0 !== 3'd2) begin failures++; $display("FAIL clip_x got de=%b x=%0d y=%0d c=%0d exp 0,160,5,2", de0, x0, y0, c0); end
    clear_pix(); set_pix(0, 3, 120, 4); done = 3'b001;
    step();
    checks++; if (de0 !== 1'b0 || x0 !== 8'd3 || y0 !== 7'd120 || g0 !== 3'b000) begin failures++; $display("FAIL clip_y got de=%b x=%0d y=%0d g=%b exp 0,3,120,000", de0, x0, y0, g0); end
    clear_pix();
    step();
  endtask

  task automatic test_watchdog();
    int cnt;
    cnt = 0;
    do_reset();
    req = 3'b110;
    step();
    req = 3'b100;
    for (int i = 0; i < 40; i++) begin
      if (gw !== 3'b010) break;
      cnt++;
      if (i == 4) begin
        checks++; if (tw !== 1'b0) begin failures++; $display("FAIL wd_early_flag got=%b exp=0", tw); end
      end
      step();
    end
    checks++; if (cnt != 9) begin failures++; $display("FAIL wd_hold_cycles got=%0d exp=9", cnt); end
    checks++; if (tw !== 1'b1 || gw !== 3'b000) begin failures++; $display("FAIL wd_flag got to=%b g=%b exp to=1 g=000", tw, gw); end
    step();
    step();
    checks++; if (gw !== 3'b100 || tw !== 1'b1) begin failures++; $display("FAIL wd_next got g=%b to=%b exp g=100 to=1", gw, tw); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    clear_pix(); set_pix(0, 1, 1, 1); done = 3'b001;
    step();
    clear_pix();
    step();
    req = 3'b010;
    step();
    checks++; if (g0 !== 3'b010) begin failures++; $display("FAIL rst_pre_grant got=%b exp=010", g0); end
    req = 3'b000;
    step();
    for (int k = 0; k < 3; k++) begin
      clear_pix(); set_pix(1, 30 + k, 40, 5);
      if (k == 2) reset = 1'b1;
      step();
    end
    checks++; if (g0 !== 3'b000 || de0 !== 1'b0 || b0 !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl got g=%b de=%b busy=%b exp 000,0,0", g0, de0, b0); end
    checks++; if (x0 !== 8'd0 || y0 !== 7'd0) begin failures++; $display("FAIL rst_mid_xy got x=%0d y=%0d exp 0,0", x0, y0); end
    reset = 1'b0;
    clear_pix();
    req = 3'b101;
    step();
    checks++; if (g0 !== 3'b001) begin failures++; $display("FAIL rst_ptr got=%b exp=001", g0); end
    req = 3'b000;
    step();
    done = 3'b001;
    step();
    clear_pix();
    step();
    req = 3'b100;
    step();
    checks++; if (g0 !== 3'b100) begin failures++; $display("FAIL rst_after got=%b exp=100", g0); end
    req = 3'b000;
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    clear_pix();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_clipping();
    test_watchdog();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single frame-buffer write port (X, Y, colour, write enable into vga_adapter) among three drawing engines: 0 = frame/slice renderer, 1 = HUD/minimap overlay, 2 = message/text overlay.
- Grants whole bursts, such as a full screen clear or one rectangle, so a burst is never interleaved with another requester's pixels.
- Round-robin or fixed priority is selected by parameter.
- A watchdog reclaims the port from a hung requester.

Parameters:
- NUM_REQ, 3: number of requesters. Fixed at 3; other values are unsupported.
- FIXED_PRIORITY, 0: 0 = round-robin; 1 = fixed priority, with requester 0 highest.
- MAX_BURST, 19201: cycles a grant may be held before forced release. Covers a 160x120 clear plus one cycle.
- SCREEN_W, 160: pixel columns. Pixels with X >= SCREEN_W are clipped.
- SCREEN_H, 120: pixel rows. Pixels with Y >= SCREEN_H are clipped.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- req  in  3  bit i: requester i wants a burst; held high until granted
- done  in  3  bit i: one-cycle pulse, last pixel of requester i's burst presented this cycle
- plot_en  in  3  bit i: requester i presents a valid pixel this cycle
- x_in  in  24  packed X, 8 bits per requester, requester i at [8i+7:8i]
- y_in  in  21  packed Y, 7 bits per requester, requester i at [7i+6:7i]
- color_in  in  9  packed colour, 3 bits per requester
- grant  out  3  one-hot grant, all zero when idle
- X  out  8  registered draw X
- Y  out  7  registered draw Y
- color_out  out  3  registered draw colour
- draw_enable  out  1  registered frame-buffer write enable
- busy  out  1  high in any state other than S_IDLE
- timeout_flag  out  1  sticky; set on watchdog release, cleared only by reset

Behaviour:
- Reset, synchronous and active-high:
  - State = S_IDLE; grant = 0; X = 0, Y = 0, color_out = 0; draw_enable = 0; busy = 0; timeout_flag = 0.
  - Round-robin pointer = 0; watchdog counter = 0.
  - Reset mid-burst abandons the burst immediately. No pixel is written in the cycle after reset.
- S_IDLE:
  - If any req bit is high, select a winner and go to S_GRANT.
  - Round-robin: search starts at the pointer and wraps 2 -> 0. Fixed priority: lowest index wins.
- S_GRANT (1 cycle):
  - grant is asserted as one-hot. It is asserted one cycle after req is sampled high in S_IDLE.
  - Watchdog is cleared. Next state is S_BURST.
- S_BURST:
  - grant is held.
  - Each cycle, the granted requester's plot_en, x, y and colour are registered to the outputs: a 1-cycle pixel latency.
  - Ungranted requesters' plot_en are ignored; their pixels are dropped with no back-pressure.
  - Clipping: if X >= SCREEN_W or Y >= SCREEN_H, draw_enable = 0 for that pixel. X, Y and colour still update.
  - Watchdog increments every cycle.
  - If done[g] is high: that cycle's pixel is still written; go to S_RELEASE.
  - Else if watchdog == MAX_BURST - 1: set timeout_flag; go to S_RELEASE.
  - done or plot_en from non-granted requesters is ignored.
- S_RELEASE (1 cycle):
  - grant = 0; draw_enable = 0 (except the registered last pixel, which appears this cycle).
  - Pointer = (g + 1) mod 3. Return to S_IDLE.
  - Minimum turnaround between grants is therefore 2 idle-grant cycles.
- Simultaneous events:
  - req rising during S_BURST waits; it is never preempted.
  - done together with the watchdog expiry is treated as a normal done: timeout_flag is not set.
  - A requester dropping req before grant is simply not granted. Dropping req while granted does not end the burst; only done or the watchdog does.
- Invariants:
  - grant is always zero or one-hot.
  - draw_enable is high only for pixels from the requester granted in the previous cycle.
  - Colour is passed through unmodified.

Test Plan:
1. Single requester: req = 001, then 4 pixels (10,20), (11,20), (12,20), (13,20) with done on the 4th -> grant = 001 one cycle after req; draw_enable high for exactly 4 cycles, each 1 cycle after its plot_en; grant drops in S_RELEASE.
2. Round-robin, FIXED_PRIORITY = 0: req = 111 held, each burst 2 pixels -> grant order 001, 010, 100, 001; no pixel from a non-granted requester appears on X/Y.
3. Fixed priority, FIXED_PRIORITY = 1: req = 110 with req[0] rising mid-burst of requester 1 -> requester 1 finishes its burst; the next grant is 001, not 100.
4. Clipping: granted requester presents (159,119), (160,5), (3,120) -> draw_enable = 1, 0, 0 respectively.
5. Watchdog: MAX_BURST = 8, granted requester never asserts done -> grant drops after 8 burst cycles; timeout_flag = 1 and stays 1; the next pending requester is granted.
6. Reset mid-burst: assert reset during the 3rd pixel -> the next cycle shows grant = 0, draw_enable = 0, X = 0, Y = 0, busy = 0; after release with req = 100, pointer 0 has been restored so grant = 100 follows normally.
